// File: rtl/axi_write_scheduler.sv
// Shares one AXI AW/W/B path among NumPorts requesters: round-robin AW grant, W routed in grant order, B by port index.
// Latency: AW/B combinational, W from the cycle after its AW; backpressure passes straight through, AW held locked until accepted.
module axi_write_scheduler #(
  parameter int NumPorts       = 3,
  parameter int AwWidth        = 64,
  parameter int WWidth         = 73,
  parameter int MaxOutstanding = 4,
  localparam int PortW = $clog2(NumPorts),
  localparam int CntW  = $clog2(MaxOutstanding + 1),
  localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumPorts-1:0]         inp_aw_valid_i,
  input  logic [NumPorts*AwWidth-1:0] inp_aw_data_i,
  output logic [NumPorts-1:0]         inp_aw_ready_o,
  input  logic [NumPorts-1:0]         inp_w_valid_i,
  input  logic [NumPorts*WWidth-1:0]  inp_w_data_i,
  input  logic [NumPorts-1:0]         inp_w_last_i,
  output logic [NumPorts-1:0]         inp_w_ready_o,
  output logic [NumPorts-1:0]         inp_b_valid_o,
  input  logic [NumPorts-1:0]         inp_b_ready_i,
  output logic                        oup_aw_valid_o,
  output logic [AwWidth-1:0]          oup_aw_data_o,
  input  logic                        oup_aw_ready_i,
  output logic                        oup_w_valid_o,
  output logic [WWidth-1:0]           oup_w_data_o,
  output logic                        oup_w_last_o,
  input  logic                        oup_w_ready_i,
  input  logic                        oup_b_valid_i,
  input  logic [PortW-1:0]            oup_b_port_i,
  output logic                        oup_b_ready_o,
  output logic                        busy_o,
  output logic                        err_o
);

  typedef enum logic {ST_ARB, ST_LOCK} state_e;
  state_e r_state, w_state_nxt;

  logic [AwWidth-1:0] w_aw_dat [NumPorts];
  logic [WWidth-1:0]  w_w_dat  [NumPorts];

  for (genvar k = 0; k < NumPorts; k++) begin : g_unpack
    assign w_aw_dat[k] = inp_aw_data_i[k*AwWidth +: AwWidth];
    assign w_w_dat[k]  = inp_w_data_i[k*WWidth +: WWidth];
  end

  logic [PortW-1:0] r_rr, r_gnt, w_gnt, w_scan, w_idx;
  logic             w_scan_found, w_aw_vld, w_aw_hs, w_can_issue;
  logic [PortW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW:0]    r_wr_ptr, r_rd_ptr;
  logic             w_full, w_empty, w_w_sel, w_pop;
  logic [PortW-1:0] w_head;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic             w_b_port_ok, w_b_hs, w_b_dec, w_err, r_err, r_busy;

  // Descending scan so the lowest offset from r_rr is the last (winning) assignment.
  always_comb begin
    w_scan       = r_rr;
    w_scan_found = 1'b0;
    w_idx        = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      w_idx = PortW'((int'(r_rr) + i) % NumPorts);
      if (inp_aw_valid_i[w_idx]) begin
        w_scan       = w_idx;
        w_scan_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_ARB;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:  if (w_aw_vld && !oup_aw_ready_i) w_state_nxt = ST_LOCK;
      ST_LOCK: if (w_aw_hs) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // While locked the issue limit is not re-checked: a presented AW must stay valid.
  always_comb begin
    w_gnt    = r_gnt;
    w_aw_vld = 1'b0;
    case (r_state)
      ST_ARB: begin
        w_gnt    = w_scan;
        w_aw_vld = w_can_issue && w_scan_found;
      end
      ST_LOCK: w_aw_vld = inp_aw_valid_i[r_gnt];
      default: w_aw_vld = 1'b0;
    endcase
    if (rst_i) w_aw_vld = 1'b0;
  end

  assign w_aw_hs        = w_aw_vld && oup_aw_ready_i;
  assign oup_aw_valid_o = w_aw_vld;
  assign oup_aw_data_o  = w_aw_dat[w_gnt];

  always_comb begin
    inp_aw_ready_o = '0;
    if (w_aw_vld) inp_aw_ready_o[w_gnt] = oup_aw_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr  <= '0;
      r_gnt <= '0;
    end else begin
      if (r_state == ST_ARB) r_gnt <= w_scan;
      if (w_aw_hs) r_rr <= (w_gnt == PortW'(NumPorts - 1)) ? '0 : w_gnt + PortW'(1);
    end
  end

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                       (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
  assign w_can_issue = !w_full && (r_cnt < CntW'(MaxOutstanding));
  assign w_head      = r_fifo[r_rd_ptr[PtrW-1:0]];
  assign w_w_sel     = !w_empty && !rst_i;

  assign oup_w_valid_o = w_w_sel && inp_w_valid_i[w_head];
  assign oup_w_data_o  = w_w_dat[w_head];
  assign oup_w_last_o  = inp_w_last_i[w_head];
  assign w_pop         = oup_w_valid_o && oup_w_ready_i && oup_w_last_o;

  always_comb begin
    inp_w_ready_o = '0;
    if (w_w_sel) inp_w_ready_o[w_head] = oup_w_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_aw_hs) r_fifo[r_wr_ptr[PtrW-1:0]] <= w_gnt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_aw_hs) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign w_b_port_ok = (32'(oup_b_port_i) < NumPorts);

  always_comb begin
    inp_b_valid_o = '0;
    oup_b_ready_o = 1'b0;
    if (w_b_port_ok && !rst_i) begin
      inp_b_valid_o[oup_b_port_i] = oup_b_valid_i;
      oup_b_ready_o               = inp_b_ready_i[oup_b_port_i];
    end
  end

  // A response with nothing outstanding is flagged but never underflows the count.
  assign w_b_hs    = oup_b_valid_i && oup_b_ready_o;
  assign w_b_dec   = w_b_hs && (r_cnt != '0);
  assign w_err     = (w_b_hs && (r_cnt == '0)) || (oup_b_valid_i && !w_b_port_ok);
  assign w_cnt_nxt = r_cnt + CntW'(w_aw_hs) - CntW'(w_b_dec);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
      r_err  <= w_err;
    end
  end

  assign busy_o = r_busy;
  assign err_o  = r_err;

endmodule

// File: tb/tb_axi_write_scheduler.sv
// Self-checking bench for axi_write_scheduler: B-routing vector table, directed corner sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_axi_write_scheduler;
  localparam int NP  = 3;
  localparam int AWW = 64;
  localparam int WW  = 73;
  localparam int MO  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NP-1:0]     inp_aw_valid, inp_aw_ready, inp_w_valid, inp_w_last, inp_w_ready;
  logic [NP-1:0]     inp_b_valid, inp_b_ready;
  logic [NP*AWW-1:0] inp_aw_data;
  logic [NP*WW-1:0]  inp_w_data;
  logic              oup_aw_valid, oup_aw_ready, oup_w_valid, oup_w_last, oup_w_ready;
  logic              oup_b_valid, oup_b_ready, busy, err;
  logic [AWW-1:0]    oup_aw_data;
  logic [WW-1:0]     oup_w_data;
  logic [1:0]        oup_b_port;

  axi_write_scheduler #(.NumPorts(NP), .AwWidth(AWW), .WWidth(WW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .inp_aw_valid_i(inp_aw_valid), .inp_aw_data_i(inp_aw_data), .inp_aw_ready_o(inp_aw_ready),
    .inp_w_valid_i(inp_w_valid), .inp_w_data_i(inp_w_data), .inp_w_last_i(inp_w_last),
    .inp_w_ready_o(inp_w_ready), .inp_b_valid_o(inp_b_valid), .inp_b_ready_i(inp_b_ready),
    .oup_aw_valid_o(oup_aw_valid), .oup_aw_data_o(oup_aw_data), .oup_aw_ready_i(oup_aw_ready),
    .oup_w_valid_o(oup_w_valid), .oup_w_data_o(oup_w_data), .oup_w_last_o(oup_w_last),
    .oup_w_ready_i(oup_w_ready), .oup_b_valid_i(oup_b_valid), .oup_b_port_i(oup_b_port),
    .oup_b_ready_o(oup_b_ready), .busy_o(busy), .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AWW-1:0] awd(input int k);
    return 64'hA5A5_0000_0000_0000 + 64'(k);
  endfunction

  function automatic logic [WW-1:0] wbeat(input int n);
    return WW'(64'hBEEF_0000_0000_0000 + 64'(n));
  endfunction

  task automatic clr();
    inp_aw_valid = '0; inp_aw_data = '0; inp_w_valid = '0; inp_w_data = '0; inp_w_last = '0;
    inp_b_ready = '0; oup_aw_ready = 1'b0; oup_w_ready = 1'b0; oup_b_valid = 1'b0; oup_b_port = '0;
    for (int k = 0; k < NP; k++) inp_aw_data[k*AWW +: AWW] = awd(k);
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       bv;
    logic [1:0] bp;
    logic [2:0] br;
    logic [2:0] exp_bv;
    logic       exp_br;
    logic       exp_err;
  } bvec_t;
  bvec_t tbl[6];

  // Reference model state
  int m_cnt, m_rr, m_lock, hs_port;
  logic m_err;
  int wq[$];
  int seen[NP];
  int ord[4];

  initial begin
    rst = 1'b1;
    clr();
    tick();
    chk("reset_aw_valid", oup_aw_valid, 0);
    chk("reset_w_valid", oup_w_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;

    // B routing table, applied with nothing outstanding
    tbl[0] = '{1'b1, 2'd1, 3'b010, 3'b010, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 2'd0, 3'b110, 3'b001, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 2'd2, 3'b100, 3'b100, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 2'd3, 3'b111, 3'b000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 2'd2, 3'b111, 3'b000, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 2'd3, 3'b111, 3'b000, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      oup_b_valid = tbl[i].bv; oup_b_port = tbl[i].bp; inp_b_ready = tbl[i].br;
      #1;
      chk($sformatf("tbl%0d_b_valid", i), inp_b_valid, tbl[i].exp_bv);
      chk($sformatf("tbl%0d_b_ready", i), oup_b_ready, tbl[i].exp_br);
      tick();
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_busy", i), busy, 0);
    end

    // Round robin with all ports requesting
    do_reset();
    inp_aw_valid = 3'b111; oup_aw_ready = 1'b1;
    inp_w_valid = 3'b111; inp_w_last = 3'b111; oup_w_ready = 1'b1; inp_b_ready = 3'b111;
    for (int k = 0; k < NP; k++) seen[k] = 0;
    for (int i = 0; i < 6; i++) begin
      oup_b_valid = (i > 0);
      oup_b_port  = (i == 0) ? 2'd0 : 2'((i - 1) % NP);
      #1;
      chk($sformatf("rr_grant%0d", i), inp_aw_ready, 1 << (i % NP));
      for (int k = 0; k < NP; k++) if (inp_aw_ready[k]) seen[k]++;
      tick();
    end
    for (int k = 0; k < NP; k++) chk($sformatf("rr_once_per_3_p%0d", k), seen[k], 2);
    chk("rr_no_err", err, 0);

    // Grant lock while AW ready is low
    do_reset();
    inp_aw_valid = 3'b010;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) inp_aw_valid[2] = 1'b1;
      if (c == 3) inp_aw_valid[0] = 1'b1;
      #1;
      chk($sformatf("lock_valid%0d", c), oup_aw_valid, 1);
      chk($sformatf("lock_data%0d", c), oup_aw_data, awd(1));
      chk($sformatf("lock_ready%0d", c), inp_aw_ready, 3'b000);
      tick();
    end
    oup_aw_ready = 1'b1;
    #1;
    chk("lock_hs_ready", inp_aw_ready, 3'b010);
    tick();
    inp_aw_valid[1] = 1'b0;
    #1;
    chk("lock_next_grant", inp_aw_ready, 3'b100);
    chk("lock_next_data", oup_aw_data, awd(2));
    tick();

    // Outstanding limit
    do_reset();
    inp_w_valid = 3'b111; inp_w_last = 3'b111; oup_w_ready = 1'b1; oup_aw_ready = 1'b1; inp_b_ready = 3'b111;
    ord[0] = 0; ord[1] = 2; ord[2] = 0; ord[3] = 1;
    for (int j = 0; j < 4; j++) begin
      inp_aw_valid = 3'(1 << ord[j]);
      #1;
      chk($sformatf("lim_grant%0d", j), inp_aw_ready, 1 << ord[j]);
      tick();
    end
    inp_aw_valid = 3'b001;
    #1;
    chk("lim_blocked_valid", oup_aw_valid, 0);
    chk("lim_blocked_ready", inp_aw_ready, 3'b000);
    chk("lim_busy", busy, 1);
    tick();
    oup_b_valid = 1'b1; oup_b_port = 2'd0;
    #1;
    chk("lim_b_ready", oup_b_ready, 1);
    chk("lim_blocked_b_cycle", oup_aw_valid, 0);
    tick();
    oup_b_valid = 1'b0;
    #1;
    chk("lim_regrant_ready", inp_aw_ready, 3'b001);
    tick();

    // W ordering: port 2 four beats, then port 0 one beat
    do_reset();
    oup_aw_ready = 1'b1; oup_w_ready = 1'b1;
    inp_aw_valid = 3'b100; inp_w_valid = 3'b101; inp_w_last = 3'b001;
    inp_w_data[0 +: WW] = wbeat(100);
    inp_w_data[2*WW +: WW] = wbeat(0);
    #1;
    chk("w_no_fallthrough_valid", oup_w_valid, 0);
    chk("w_no_fallthrough_ready", inp_w_ready, 3'b000);
    chk("w_aw2_grant", inp_aw_ready, 3'b100);
    tick();
    inp_aw_valid = 3'b001;
    for (int c = 1; c <= 4; c++) begin
      inp_w_data[2*WW +: WW] = wbeat(c - 1);
      inp_w_last[2] = (c == 4);
      #1;
      if (c == 1) chk("w_aw0_grant", inp_aw_ready, 3'b001);
      chk($sformatf("w_p2_valid%0d", c), oup_w_valid, 1);
      chk($sformatf("w_p2_data%0d", c), oup_w_data, wbeat(c - 1));
      chk($sformatf("w_p2_last%0d", c), oup_w_last, c == 4);
      chk($sformatf("w_p2_ready%0d", c), inp_w_ready, 3'b100);
      tick();
      inp_aw_valid = 3'b000;
    end
    inp_w_valid = 3'b001;
    #1;
    chk("w_p0_data", oup_w_data, wbeat(100));
    chk("w_p0_last", oup_w_last, 1);
    chk("w_p0_ready", inp_w_ready, 3'b001);
    tick();
    #1;
    chk("w_empty_valid", oup_w_valid, 0);
    chk("w_empty_ready", inp_w_ready, 3'b000);

    // Simultaneous AW and B with two outstanding
    do_reset();
    inp_w_valid = 3'b111; inp_w_last = 3'b111; oup_w_ready = 1'b1; oup_aw_ready = 1'b1; inp_b_ready = 3'b111;
    inp_aw_valid = 3'b001; tick();
    inp_aw_valid = 3'b010; tick();
    inp_aw_valid = 3'b100; oup_b_valid = 1'b1; oup_b_port = 2'd0;
    #1;
    chk("same_aw_ready", inp_aw_ready, 3'b100);
    chk("same_b_ready", oup_b_ready, 1);
    tick();
    oup_b_valid = 1'b0;
    chk("same_busy", busy, 1);
    chk("same_no_err", err, 0);
    inp_aw_valid = 3'b001;
    #1;
    chk("same_fill3", inp_aw_ready, 3'b001);
    tick();
    inp_aw_valid = 3'b010;
    #1;
    chk("same_fill4", inp_aw_ready, 3'b010);
    tick();
    inp_aw_valid = 3'b100;
    #1;
    chk("same_full_blocked", oup_aw_valid, 0);

    // B with nothing outstanding
    do_reset();
    oup_b_valid = 1'b1; oup_b_port = 2'd1; inp_b_ready = 3'b010;
    #1;
    chk("b0_valid_vec", inp_b_valid, 3'b010);
    tick();
    oup_b_valid = 1'b0;
    chk("b0_err_pulse", err, 1);
    chk("b0_busy", busy, 0);
    tick();
    chk("b0_err_one_cycle", err, 0);
    chk("b0_busy_after", busy, 0);

    // Reset in the middle of a burst
    do_reset();
    oup_aw_ready = 1'b1; oup_w_ready = 1'b1; inp_b_ready = 3'b111;
    inp_aw_valid = 3'b100;
    tick();
    inp_aw_valid = 3'b000; inp_w_valid = 3'b100; inp_w_last = 3'b000;
    #1;
    chk("mid_burst_w_valid", oup_w_valid, 1);
    tick();
    rst = 1'b1; inp_aw_valid = 3'b001; oup_b_valid = 1'b1; oup_b_port = 2'd1;
    #1;
    chk("rst_cycle_aw_valid", oup_aw_valid, 0);
    chk("rst_cycle_aw_ready", inp_aw_ready, 3'b000);
    chk("rst_cycle_w_valid", oup_w_valid, 0);
    chk("rst_cycle_w_ready", inp_w_ready, 3'b000);
    chk("rst_cycle_b_valid", inp_b_valid, 3'b000);
    chk("rst_cycle_b_ready", oup_b_ready, 0);
    tick();
    rst = 1'b0; inp_aw_valid = 3'b000; oup_b_valid = 1'b0;
    #1;
    chk("post_rst_w_valid", oup_w_valid, 0);
    chk("post_rst_w_ready", inp_w_ready, 3'b000);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err, 0);

    // Randomized traffic against the reference model
    do_reset();
    m_cnt = 0; m_rr = 0; m_lock = -1; hs_port = -1; m_err = 1'b0;
    wq.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int g, h, p;
      logic [2:0] e_aw_r, e_w_r, e_b_v;
      logic e_b_r, e_w_v, aw_hs, b_hs, pop;
      if (hs_port >= 0) inp_aw_valid[hs_port] = 1'b0;
      for (int k = 0; k < NP; k++) begin
        if (!inp_aw_valid[k] && $urandom_range(2) == 0) begin
          inp_aw_valid[k] = 1'b1;
          inp_aw_data[k*AWW +: AWW] = {$urandom, $urandom};
        end
        inp_w_last[k] = ($urandom_range(2) == 0);
        inp_w_data[k*WW +: WW] = WW'({$urandom, $urandom, $urandom});
      end
      oup_aw_ready = ($urandom_range(3) != 0);
      inp_w_valid  = 3'($urandom);
      oup_w_ready  = 1'($urandom_range(1));
      inp_b_ready  = 3'($urandom);
      if (m_cnt > 0 && $urandom_range(2) == 0) begin
        oup_b_valid = 1'b1; oup_b_port = 2'($urandom_range(NP - 1));
      end else begin
        oup_b_valid = 1'b0; oup_b_port = 2'($urandom_range(3));
      end
      #1;
      g = -1;
      if (m_lock >= 0) g = m_lock;
      else if (wq.size() < MO && m_cnt < MO)
        for (int i = 0; i < NP; i++) begin
          p = (m_rr + i) % NP;
          if (g < 0 && inp_aw_valid[p]) g = p;
        end
      e_aw_r = '0;
      if (g >= 0) e_aw_r[g] = oup_aw_ready;
      chk("rnd_aw_valid", oup_aw_valid, g >= 0);
      chk("rnd_aw_ready", inp_aw_ready, e_aw_r);
      if (g >= 0) chk("rnd_aw_data", oup_aw_data, inp_aw_data[g*AWW +: AWW]);
      e_w_v = 1'b0; e_w_r = '0; h = 0;
      if (wq.size() > 0) begin
        h = wq[0];
        e_w_v = inp_w_valid[h];
        e_w_r[h] = oup_w_ready;
      end
      chk("rnd_w_valid", oup_w_valid, e_w_v);
      chk("rnd_w_ready", inp_w_ready, e_w_r);
      if (e_w_v) begin
        chk("rnd_w_data", oup_w_data, inp_w_data[h*WW +: WW]);
        chk("rnd_w_last", oup_w_last, inp_w_last[h]);
      end
      e_b_v = '0; e_b_r = 1'b0;
      if (int'(oup_b_port) < NP) begin
        e_b_v[oup_b_port] = oup_b_valid;
        e_b_r = inp_b_ready[oup_b_port];
      end
      chk("rnd_b_valid", inp_b_valid, e_b_v);
      chk("rnd_b_ready", oup_b_ready, e_b_r);
      chk("rnd_err", err, m_err);
      chk("rnd_busy", busy, m_cnt != 0);
      aw_hs = (g >= 0) && oup_aw_ready;
      pop   = e_w_v && oup_w_ready && inp_w_last[h];
      b_hs  = oup_b_valid && e_b_r;
      m_err = (b_hs && m_cnt == 0) || (oup_b_valid && int'(oup_b_port) >= NP);
      if (pop) void'(wq.pop_front());
      if (aw_hs) begin
        wq.push_back(g);
        m_rr = (g + 1) % NP;
        m_lock = -1;
        hs_port = g;
      end else begin
        hs_port = -1;
        if (g >= 0) m_lock = g;
      end
      if (aw_hs && !(b_hs && m_cnt > 0)) m_cnt++;
      else if (!aw_hs && b_hs && m_cnt > 0) m_cnt--;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
